// File: rtl/packet_pkg.sv
// Constants and types shared by the packet classifier and the downstream buffer/drop stage.
package packet_pkg;

  localparam int unsigned MIN_PCKT_SIZE  = 8;
  localparam int unsigned MAX_PCKT_SIZE  = 190;
  localparam int unsigned MAC_WIDTH      = 48;
  localparam int unsigned BEAT_CNT_WIDTH = 8;

  localparam logic [MAC_WIDTH-1:0] BCAST_MAC = 48'hFFFF_FFFF_FFFF;

  localparam logic CH_DROP = 1'b0;
  localparam logic CH_PASS = 1'b1;

  typedef enum logic {
    IDLE_S,
    PKT_S
  } state_e;

endpackage

// File: rtl/avalon_st_if.sv
// Avalon-ST stream bundle; sink/src modports are seen from the block that owns the port.
interface avalon_st_if #(
  parameter int unsigned DWIDTH        = 64,
  parameter int unsigned EMPTY_WIDTH   = 3,
  parameter int unsigned CHANNEL_WIDTH = 1
);

  logic                     valid;
  logic                     ready;
  logic [DWIDTH-1:0]        data;
  logic [EMPTY_WIDTH-1:0]   empty;
  logic                     startofpacket;
  logic                     endofpacket;
  logic [CHANNEL_WIDTH-1:0] channel;

  modport sink (
    input  valid, data, empty, startofpacket, endofpacket, channel,
    output ready
  );

  modport src (
    output valid, data, empty, startofpacket, endofpacket, channel,
    input  ready
  );

endinterface

// File: rtl/ast_pipe_reg.sv
// One-deep Avalon-ST register slice; accepts a new beat whenever the slot is empty or draining.
module ast_pipe_reg #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned EMPTY_WIDTH   = 3,
  parameter int unsigned CHANNEL_WIDTH = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     in_valid_i,
  output logic                     in_ready_c_o,
  input  logic [DATA_WIDTH-1:0]    in_data_i,
  input  logic [EMPTY_WIDTH-1:0]   in_empty_i,
  input  logic                     in_sop_i,
  input  logic                     in_eop_i,
  input  logic [CHANNEL_WIDTH-1:0] in_channel_i,
  output logic                     out_valid_o,
  input  logic                     out_ready_i,
  output logic [DATA_WIDTH-1:0]    out_data_o,
  output logic [EMPTY_WIDTH-1:0]   out_empty_o,
  output logic                     out_sop_o,
  output logic                     out_eop_o,
  output logic [CHANNEL_WIDTH-1:0] out_channel_o
);

  logic                     valid_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic [EMPTY_WIDTH-1:0]   empty_q;
  logic                     sop_q;
  logic                     eop_q;
  logic [CHANNEL_WIDTH-1:0] channel_q;
  logic                     load_c;

  assign in_ready_c_o = ~rst_i & (out_ready_i | ~valid_q);
  assign load_c       = in_valid_i & in_ready_c_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q   <= 1'b0;
      data_q    <= '0;
      empty_q   <= '0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      channel_q <= '0;
    end else begin
      if (load_c) begin
        valid_q   <= 1'b1;
        data_q    <= in_data_i;
        empty_q   <= in_empty_i;
        sop_q     <= in_sop_i;
        eop_q     <= in_eop_i;
        channel_q <= in_channel_i;
      end else if (out_ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign out_valid_o   = valid_q;
  assign out_data_o    = data_q;
  assign out_empty_o   = empty_q;
  assign out_sop_o     = sop_q;
  assign out_eop_o     = eop_q;
  assign out_channel_o = channel_q;

endmodule

// File: rtl/packet_classifier.sv
// Tags each Avalon-ST packet with a pass/drop verdict from destination MAC and beat count;
// the verdict is final on the eop beat. One register stage, never stalls for classification.
module packet_classifier
  import packet_pkg::*;
#(
  parameter int unsigned AST_DWIDTH    = 64,
  parameter int unsigned CHANNEL_WIDTH = 1,
  parameter int unsigned CNT_WIDTH     = 32
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic                 filter_en_i,
  input  logic [47:0]          mac_addr_i,
  avalon_st_if.sink            ast_sink_if,
  avalon_st_if.src             ast_src_if,
  output logic [CNT_WIDTH-1:0] pass_cnt_o,
  output logic [CNT_WIDTH-1:0] drop_cnt_o,
  output logic [CNT_WIDTH-1:0] err_cnt_o
);

  localparam int unsigned EMPTY_WIDTH = $clog2(AST_DWIDTH / 8);
  localparam logic [BEAT_CNT_WIDTH-1:0] MIN_BEATS = BEAT_CNT_WIDTH'(MIN_PCKT_SIZE);
  localparam logic [BEAT_CNT_WIDTH-1:0] MAX_BEATS = BEAT_CNT_WIDTH'(MAX_PCKT_SIZE);

  state_e                    state_q, state_d;
  logic [BEAT_CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
  logic                      keep_q, keep_d;
  logic                      err_in_pkt_q, err_in_pkt_d;
  logic [CNT_WIDTH-1:0]      pass_cnt_q, pass_cnt_d;
  logic [CNT_WIDTH-1:0]      drop_cnt_q, drop_cnt_d;
  logic [CNT_WIDTH-1:0]      err_cnt_q, err_cnt_d;

  logic                      pipe_ready_c;
  logic                      accept_c;
  logic                      sop_c;
  logic                      eop_c;
  logic [MAC_WIDTH-1:0]      dest_c;
  logic                      mac_ok_c;
  logic                      fwd_c;
  logic                      keep_c;
  logic [BEAT_CNT_WIDTH-1:0] cnt_c;
  logic                      err_c;
  logic                      len_ok_c;
  logic                      verdict_c;
  logic                      sink_channel_unused;

  assign sop_c    = ast_sink_if.startofpacket;
  assign eop_c    = ast_sink_if.endofpacket;
  assign dest_c   = ast_sink_if.data[AST_DWIDTH-1 -: MAC_WIDTH];
  assign accept_c = ast_sink_if.valid & pipe_ready_c;

  assign ast_sink_if.ready   = pipe_ready_c;
  assign sink_channel_unused = ^ast_sink_if.channel;

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      state_q      <= IDLE_S;
      beat_cnt_q   <= '0;
      keep_q       <= 1'b0;
      err_in_pkt_q <= 1'b0;
      pass_cnt_q   <= '0;
      drop_cnt_q   <= '0;
      err_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      beat_cnt_q   <= beat_cnt_d;
      keep_q       <= keep_d;
      err_in_pkt_q <= err_in_pkt_d;
      pass_cnt_q   <= pass_cnt_d;
      drop_cnt_q   <= drop_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  // Per-beat classification; packet context only advances on beats that are forwarded.
  always_comb begin
    state_d      = state_q;
    beat_cnt_d   = beat_cnt_q;
    keep_d       = keep_q;
    err_in_pkt_d = err_in_pkt_q;
    pass_cnt_d   = pass_cnt_q;
    drop_cnt_d   = drop_cnt_q;
    err_cnt_d    = err_cnt_q;

    mac_ok_c = ~filter_en_i | (dest_c == mac_addr_i) | (dest_c == BCAST_MAC);
    fwd_c    = sop_c | (state_q == PKT_S);

    if (sop_c) begin
      keep_c = mac_ok_c;
      cnt_c  = BEAT_CNT_WIDTH'(1);
      err_c  = (state_q == PKT_S);
    end else begin
      keep_c = keep_q;
      cnt_c  = (beat_cnt_q == '1) ? beat_cnt_q : beat_cnt_q + BEAT_CNT_WIDTH'(1);
      err_c  = err_in_pkt_q;
    end

    len_ok_c  = (cnt_c >= MIN_BEATS) & (cnt_c <= MAX_BEATS);
    verdict_c = eop_c ? (keep_c & len_ok_c & ~err_c) : keep_c;

    if (accept_c) begin
      if (fwd_c) begin
        keep_d       = keep_c;
        beat_cnt_d   = cnt_c;
        err_in_pkt_d = err_c;
        if (eop_c) begin
          if (verdict_c == CH_PASS) pass_cnt_d = pass_cnt_q + CNT_WIDTH'(1);
          else                      drop_cnt_d = drop_cnt_q + CNT_WIDTH'(1);
        end
      end
      if (~fwd_c | (sop_c & (state_q == PKT_S))) begin
        err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
      end
      if (sop_c)      state_d = eop_c ? IDLE_S : PKT_S;
      else if (eop_c) state_d = IDLE_S;
    end
  end

  ast_pipe_reg #(
    .DATA_WIDTH    (AST_DWIDTH),
    .EMPTY_WIDTH   (EMPTY_WIDTH),
    .CHANNEL_WIDTH (CHANNEL_WIDTH)
  ) u_pipe (
    .clk_i         (clk_i),
    .rst_i         (srst_i),
    .in_valid_i    (ast_sink_if.valid & fwd_c),
    .in_ready_c_o  (pipe_ready_c),
    .in_data_i     (ast_sink_if.data),
    .in_empty_i    (ast_sink_if.empty),
    .in_sop_i      (sop_c),
    .in_eop_i      (eop_c),
    .in_channel_i  (CHANNEL_WIDTH'(verdict_c)),
    .out_valid_o   (ast_src_if.valid),
    .out_ready_i   (ast_src_if.ready),
    .out_data_o    (ast_src_if.data),
    .out_empty_o   (ast_src_if.empty),
    .out_sop_o     (ast_src_if.startofpacket),
    .out_eop_o     (ast_src_if.endofpacket),
    .out_channel_o (ast_src_if.channel)
  );

  assign pass_cnt_o = pass_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
  assign err_cnt_o  = err_cnt_q;

endmodule
